mul_float_normalize: RTL and testbench

MUL_FLOAT_NORMALIZE -- requirements
Module: mul_float_normalize

---
 rtl/mul_float_normalize_if.sv | 36 +++
 rtl/mul_float_normalize.sv | 87 ++++++++
 tb/tb_mul_float_normalize.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mul_float_normalize_if.sv
// mul_float_normalize_if: upstream product bus and downstream rounded result bus
// master drives the product fields and downstream backpressure, slave is the normalizer
// in_*: upstream valid/busy, sign, exponent, raw product; exp_*/fract_*: operand exception flags
// out_*: downstream valid/busy, IEEE-754 result; flag_*: status aligned with out_result
interface mul_float_normalize_if;
    logic        in_req;
    logic        in_busy;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_fract;
    logic        exp_a0;
    logic        exp_b0;
    logic        exp_a1;
    logic        exp_b1;
    logic        fract_a0;
    logic        fract_b0;
    logic        out_valid;
    logic        out_busy;
    logic [31:0] out_result;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_invalid;
    logic        flag_inexact;
    modport master (
        output in_req, in_sign, in_exp, in_fract, exp_a0, exp_b0, exp_a1, exp_b1,
               fract_a0, fract_b0, out_busy,
        input  in_busy, out_valid, out_result, flag_overflow, flag_underflow,
               flag_invalid, flag_inexact
    );
    modport slave (
        input  in_req, in_sign, in_exp, in_fract, exp_a0, exp_b0, exp_a1, exp_b1,
               fract_a0, fract_b0, out_busy,
        output in_busy, out_valid, out_result, flag_overflow, flag_underflow,
               flag_invalid, flag_inexact
    );
endinterface

// File: rtl/mul_float_normalize.sv
// mul_float_normalize: 2-stage normalize and round-to-nearest-even of a 24x24 significand product
// iCLOCK: clock; inRESET: async active-low clear; iRESET_SYNC: sync active-high clear
// bus: upstream product in, downstream single-precision result and flags out
module mul_float_normalize (
    input logic             iCLOCK,
    input logic             inRESET,
    input logic             iRESET_SYNC,
    mul_float_normalize_if.slave bus
);
    typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN} class_t;
    logic               hi;
    logic [22:0]        n_mant;
    logic               n_guard;
    logic               n_sticky;
    logic [10:0]        n_exp;
    class_t             n_class;
    logic               s0_valid;
    logic               s0_sign;
    logic [22:0]        s0_mant;
    logic               s0_guard;
    logic               s0_sticky;
    logic [10:0]        s0_exp;
    class_t             s0_class;
    logic               inc;
    logic               carry;
    logic [22:0]        r_mant;
    logic signed [10:0] r_exp;
    logic               ovf;
    logic               unf;
    logic [31:0]        n_result;
    logic [3:0]         n_flags;

    assign bus.in_busy = bus.out_busy;

    // a product of two [1,2) significands lies in [1,4); bit 47 marks the upper binade
    assign hi       = bus.in_fract[47];
    assign n_mant   = hi ? bus.in_fract[46:24] : bus.in_fract[45:23];
    assign n_guard  = hi ? bus.in_fract[23] : bus.in_fract[22];
    assign n_sticky = hi ? |bus.in_fract[22:0] : |bus.in_fract[21:0];
    assign n_exp    = {bus.in_exp[9], bus.in_exp} + {10'd0, hi};
    assign n_class  = ((bus.exp_a1 && !bus.fract_a0) || (bus.exp_b1 && !bus.fract_b0) ||
                       (bus.exp_a1 && bus.exp_b0) || (bus.exp_b1 && bus.exp_a0)) ? NAN :
                      (bus.exp_a1 || bus.exp_b1) ? INF :
                      (bus.exp_a0 || bus.exp_b0) ? ZERO : NORMAL;

    // mantissa overflow on rounding leaves all-zero bits and bumps the exponent
    assign inc           = s0_guard && (s0_sticky || s0_mant[0]);
    assign {carry, r_mant} = {1'b0, s0_mant} + 24'(inc);
    assign r_exp         = s0_exp + {10'd0, carry};
    assign ovf           = (s0_class == NORMAL) && (r_exp >= 11'sd255);
    assign unf           = (s0_class == NORMAL) && (r_exp <= 11'sd0);
    assign n_result      = (s0_class == NAN) ? 32'h7FC0_0000 :
                           (s0_class == INF || ovf) ? {s0_sign, 8'hFF, 23'h0} :
                           (s0_class == ZERO || unf) ? {s0_sign, 31'h0} :
                           {s0_sign, r_exp[7:0], r_mant};
    assign n_flags       = {ovf, unf, s0_class == NAN,
                            ovf || unf || (s0_class == NORMAL && (s0_guard || s0_sticky))};

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET || iRESET_SYNC) begin
            s0_valid           <= 1'b0;
            s0_sign            <= 1'b0;
            s0_mant            <= 23'h0;
            s0_guard           <= 1'b0;
            s0_sticky          <= 1'b0;
            s0_exp             <= 11'h0;
            s0_class           <= NORMAL;
            bus.out_valid      <= 1'b0;
            bus.out_result     <= 32'h0;
            bus.flag_overflow  <= 1'b0;
            bus.flag_underflow <= 1'b0;
            bus.flag_invalid   <= 1'b0;
            bus.flag_inexact   <= 1'b0;
        end else if (!bus.out_busy) begin
            s0_valid           <= bus.in_req;
            s0_sign            <= bus.in_sign;
            s0_mant            <= n_mant;
            s0_guard           <= n_guard;
            s0_sticky          <= n_sticky;
            s0_exp             <= n_exp;
            s0_class           <= n_class;
            bus.out_valid      <= s0_valid;
            bus.out_result     <= n_result;
            {bus.flag_overflow, bus.flag_underflow, bus.flag_invalid, bus.flag_inexact} <= n_flags;
        end
    end
endmodule

// File: tb/tb_mul_float_normalize.sv
// tb_mul_float_normalize: directed scoreboard bench for mul_float_normalize
module tb_mul_float_normalize;
    typedef struct packed {logic [31:0] r; logic [3:0] f;} exp_t;
    logic iCLOCK = 1'b0;
    logic inRESET = 1'b1;
    logic iRESET_SYNC = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t mon_e;

    mul_float_normalize_if bus();

    mul_float_normalize dut (
        .iCLOCK(iCLOCK),
        .inRESET(inRESET),
        .iRESET_SYNC(iRESET_SYNC),
        .bus(bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // x = {a0, b0, a1, b1, fract_a0, fract_b0}
    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] fr, input logic [5:0] x);
        bus.in_req   = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_fract = fr;
        {bus.exp_a0, bus.exp_b0, bus.exp_a1, bus.exp_b1, bus.fract_a0, bus.fract_b0} = x;
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] fr, input logic [5:0] x,
                        input logic [31:0] r, input logic [3:0] f);
        drive(s, e, fr, x);
        @(posedge iCLOCK);
        if (!bus.in_busy) q.push_back({r, f});
        #1 bus.in_req = 1'b0;
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h0);
        chk({tag, "_result"}, bus.out_result, 32'h0);
        chk({tag, "_flags"}, {28'h0, bus.flag_overflow, bus.flag_underflow, bus.flag_invalid,
                              bus.flag_inexact}, 32'h0);
    endtask

    always @(negedge iCLOCK) begin
        if (inRESET && bus.out_valid && !bus.out_busy) begin
            if (q.size() == 0) chk("spurious_output", 32'(q.size()), 32'd1);
            else begin
                mon_e = q.pop_front();
                chk("result", bus.out_result, mon_e.r);
                chk("flags", {28'h0, bus.flag_overflow, bus.flag_underflow, bus.flag_invalid,
                              bus.flag_inexact}, {28'h0, mon_e.f});
            end
        end
    end

    initial begin
        bus.in_req = 1'b0; bus.in_sign = 1'b0; bus.in_exp = 10'h0; bus.in_fract = 48'h0;
        {bus.exp_a0, bus.exp_b0, bus.exp_a1, bus.exp_b1, bus.fract_a0, bus.fract_b0} = 6'h0;
        bus.out_busy = 1'b0;
        #2 inRESET = 1'b0;
        #3 chk_clear("reset");
        @(posedge iCLOCK); #1 inRESET = 1'b1;
        // flags: {overflow, underflow, invalid, inexact}
        send(1'b0, 10'd127, 48'h9000_0000_0000, 6'h00, 32'h4010_0000, 4'b0000);
        send(1'b0, 10'd129, 48'h6000_0000_0000, 6'h00, 32'h40C0_0000, 4'b0000);
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 6'h00, 32'h3F80_0002, 4'b0001);
        send(1'b1, 10'd300, 48'h8000_0000_0000, 6'h00, 32'hFF80_0000, 4'b1001);
        send(1'b1, 10'h381, 48'h8000_0000_0000, 6'h00, 32'h8000_0000, 4'b0101);
        send(1'b1, 10'd127, 48'h8000_0000_0000, 6'b001000, 32'h7FC0_0000, 4'b0010);
        send(1'b0, 10'd127, 48'h8000_0000_0000, 6'b011010, 32'h7FC0_0000, 4'b0010);
        send(1'b0, 10'd127, 48'h8000_0000_0000, 6'b001010, 32'h7F80_0000, 4'b0000);
        send(1'b1, 10'd127, 48'h8000_0000_0000, 6'b010000, 32'h8000_0000, 4'b0000);
        send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 6'h00, 32'h4000_0000, 4'b0001);
        send(1'b0, 10'd127, 48'h4000_0040_0000, 6'h00, 32'h3F80_0000, 4'b0001);
        send(1'b0, 10'd253, 48'hFFFF_FF80_0000, 6'h00, 32'h7F80_0000, 4'b1001);
        send(1'b0, 10'd254, 48'h4000_0000_0000, 6'h00, 32'h7F00_0000, 4'b0000);
        send(1'b0, 10'd1,   48'h4000_0000_0000, 6'h00, 32'h0080_0000, 4'b0000);
        send(1'b0, 10'd0,   48'h4000_0000_0000, 6'h00, 32'h0000_0000, 4'b0101);
        repeat (4) @(posedge iCLOCK);
        #1;
        // backpressure: third transfer waits while the first sits frozen at the output
        send(1'b0, 10'd127, 48'h9000_0000_0000, 6'h00, 32'h4010_0000, 4'b0000);
        send(1'b0, 10'd129, 48'h6000_0000_0000, 6'h00, 32'h40C0_0000, 4'b0000);
        drive(1'b0, 10'd127, 48'h4000_00C0_0000, 6'h00);
        bus.out_busy = 1'b1;
        repeat (3) begin
            @(negedge iCLOCK);
            chk("hold_valid", {31'h0, bus.out_valid}, 32'h1);
            chk("hold_result", bus.out_result, 32'h4010_0000);
            chk("hold_busy", {31'h0, bus.in_busy}, 32'h1);
            @(posedge iCLOCK); #1;
        end
        bus.out_busy = 1'b0;
        @(posedge iCLOCK);
        q.push_back({32'h3F80_0002, 4'b0001});
        #1 bus.in_req = 1'b0;
        repeat (4) @(posedge iCLOCK);
        #1;
        // synchronous clear with both stages full, even under backpressure
        send(1'b0, 10'd127, 48'h9000_0000_0000, 6'h00, 32'h4010_0000, 4'b0000);
        send(1'b0, 10'd129, 48'h6000_0000_0000, 6'h00, 32'h40C0_0000, 4'b0000);
        iRESET_SYNC = 1'b1;
        bus.out_busy = 1'b1;
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b0;
        bus.out_busy = 1'b0;
        q.delete();
        chk_clear("sync_reset");
        @(posedge iCLOCK); #1;
        chk("sync_reset_stay", {31'h0, bus.out_valid}, 32'h0);
        // asynchronous clear mid-stream, checked before any further edge
        send(1'b1, 10'd127, 48'h9000_0000_0000, 6'h00, 32'hC010_0000, 4'b0000);
        send(1'b0, 10'd129, 48'h6000_0000_0000, 6'h00, 32'h40C0_0000, 4'b0000);
        bus.out_busy = 1'b1;
        #2 inRESET = 1'b0;
        #1 chk_clear("async_reset");
        q.delete();
        @(posedge iCLOCK); #1;
        inRESET = 1'b1;
        bus.out_busy = 1'b0;
        send(1'b1, 10'd127, 48'h9000_0000_0000, 6'h00, 32'hC010_0000, 4'b0000);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge iCLOCK);
        #1 chk("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
